// File: rtl/instr_issuer.sv
// Purpose : program buffer of DEPTH 12-bit words, loaded in IDLE, issued once (or looped) in RUN.
// Latency : first word is presented 1 cycle after start is sampled; one word per cycle after that.
// Backpr. : out_ready low holds instruction/out_valid steady; no word is skipped or duplicated.
//
// Optional feature: define ISSUE_REPEAT_EN to add the repeat_mode input.
//
// Ports
//   clk, rst     single clock, asynchronous active-high reset
//   load_en      append load_data to the program (IDLE only, dropped when full)
//   load_data    instruction word {opcode[11:9], a[8:6], b[5:3], d[2:0]}
//   clear        empty the program and clear overflow (IDLE only, top priority)
//   start        begin issuing the stored program (IDLE only)
//   out_ready    downstream accepts the presented word
//   repeat_mode  (ISSUE_REPEAT_EN only) at the last transfer, loop back to word 0
//   instruction  registered issued word, 0 whenever out_valid is low
//   out_valid    instruction is valid
//   busy         high in RUN
//   done         one-cycle pulse after the last transfer
//   prog_count   number of stored words
//   full         prog_count == DEPTH
//   overflow     sticky: a load was attempted while full
module instr_issuer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [11:0]              load_data,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     out_ready,
`ifdef ISSUE_REPEAT_EN
    input  logic                     repeat_mode,
`endif
    output logic [11:0]              instruction,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   prog_count,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [11:0]      prog_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_nxt;
    logic [11:0]      instr_nxt;
    logic             valid_nxt;
    logic             mem_we;
    logic             last_word;
    logic             loop_back;

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign full = (prog_count == DEPTH_C);

    // rd_ptr addresses the word currently on the output
    assign last_word = ({1'b0, rd_ptr} == (prog_count - CNT_W'(1)));

`ifdef ISSUE_REPEAT_EN
    assign loop_back = repeat_mode;
`else
    assign loop_back = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            prog_count  <= '0;
            overflow    <= 1'b0;
            instruction <= 12'h000;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            prog_count  <= count_nxt;
            overflow    <= ovf_nxt;
            instruction <= instr_nxt;
            out_valid   <= valid_nxt;
        end
    end

    // Program storage is intentionally not reset; prog_count = 0 hides stale words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            prog_mem[wr_ptr] <= load_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = prog_count;
        ovf_nxt    = overflow;
        instr_nxt  = instruction;
        valid_nxt  = out_valid;
        mem_we     = 1'b0;

        case (state)
            IDLE: begin
                instr_nxt = 12'h000;
                valid_nxt = 1'b0;
                if (clear) begin
                    wr_ptr_nxt = '0;
                    count_nxt  = '0;
                    ovf_nxt    = 1'b0;
                end else if (start) begin
                    if (prog_count != '0) begin
                        state_nxt  = RUN;
                        rd_ptr_nxt = '0;
                        instr_nxt  = prog_mem[0];
                        valid_nxt  = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (load_en) begin
                    if (!full) begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + AW'(1);
                        count_nxt  = prog_count + CNT_W'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end

            RUN: begin
                if (out_valid && out_ready) begin
                    if (last_word) begin
                        if (loop_back) begin
                            rd_ptr_nxt = '0;
                            instr_nxt  = prog_mem[0];
                        end else begin
                            state_nxt = DONE;
                            instr_nxt = 12'h000;
                            valid_nxt = 1'b0;
                        end
                    end else begin
                        rd_ptr_nxt = rd_ptr + AW'(1);
                        instr_nxt  = prog_mem[rd_ptr + AW'(1)];
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                instr_nxt = 12'h000;
                valid_nxt = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
                instr_nxt = 12'h000;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Purpose : directed bench for instr_issuer with hand-computed expectations.
// Latency : each step advances one clock; outputs are sampled 1 time unit after posedge.
// Backpr. : exercises out_ready stalls, full/overflow, empty start, reset mid-run.
module tb_instr_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [11:0] load_data;
    logic        clear;
    logic        start;
    logic        out_ready;
`ifdef ISSUE_REPEAT_EN
    logic        repeat_mode;
`endif
    logic [11:0] instruction;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [4:0]  prog_count;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    instr_issuer #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_data   (load_data),
        .clear       (clear),
        .start       (start),
        .out_ready   (out_ready),
`ifdef ISSUE_REPEAT_EN
        .repeat_mode (repeat_mode),
`endif
        .instruction (instruction),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .prog_count  (prog_count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] w);
        load_en   = 1'b1;
        load_data = w;
        tick();
        load_en   = 1'b0;
    endtask

    // word presented: instruction and out_valid together
    task automatic chk_word(input string tag, input logic [11:0] w);
        chk({tag, "_instr"}, 32'(instruction), 32'(w));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instr"}, 32'(instruction), 32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_count"}, 32'(prog_count), 32'd0);
        chk({tag, "_full"},  32'(full), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_data = 12'h000; clear = 1'b0;
        start = 1'b0; out_ready = 1'b0;
`ifdef ISSUE_REPEAT_EN
        repeat_mode = 1'b0;
`endif
        #3;
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // single pass of three words with out_ready held high
        load(12'h0C5);
        load(12'h1C5);
        load(12'hED9);
        chk("count3", 32'(prog_count), 32'd3);
        chk("full3", 32'(full), 32'd0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("p1_w0", 12'h0C5);
        chk("p1_busy", 32'(busy), 32'd1);
        tick();
        chk_word("p1_w1", 12'h1C5);
        tick();
        chk_word("p1_w2", 12'hED9);
        tick();
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_vld_drop", 32'(out_valid), 32'd0);
        chk("p1_instr_zero", 32'(instruction), 32'h0);
        tick();
        chk("p1_done_once", 32'(done), 32'd0);
        chk("p1_idle", 32'(busy), 32'd0);
        chk("p1_retained", 32'(prog_count), 32'd3);

        // re-issue with a 4-cycle stall on word 2; loads in RUN are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("p2_w0", 12'h0C5);
        tick();
        chk_word("p2_w1", 12'h1C5);
        out_ready = 1'b0;
        load_en   = 1'b1;
        load_data = 12'h777;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_word("p2_stall", 12'h1C5);
        end
        load_en   = 1'b0;
        chk("p2_load_ignored", 32'(prog_count), 32'd3);
        out_ready = 1'b1;
        tick();
        chk_word("p2_w2", 12'hED9);
        tick();
        chk("p2_done", 32'(done), 32'd1);
        tick();
        chk("p2_done_once", 32'(done), 32'd0);

        // fill to 16, overflow on 17th, clear (with a simultaneous load)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", 32'(prog_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            load(12'(12'h200 + i));
        end
        chk("f16_count", 32'(prog_count), 32'd16);
        chk("f16_full", 32'(full), 32'd1);
        chk("f16_ovf", 32'(overflow), 32'd0);
        load(12'hFFF);
        chk("f17_count", 32'(prog_count), 32'd16);
        chk("f17_full", 32'(full), 32'd1);
        chk("f17_ovf", 32'(overflow), 32'd1);
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear     = 1'b1;
        load_en   = 1'b1;
        load_data = 12'h123;
        tick();
        clear   = 1'b0;
        load_en = 1'b0;
        chk("clr2_count", 32'(prog_count), 32'd0);
        chk("clr2_ovf", 32'(overflow), 32'd0);
        chk("clr2_full", 32'(full), 32'd0);

        // start on an empty program, with a competing load
        start     = 1'b1;
        load_en   = 1'b1;
        load_data = 12'h456;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_load_ignored", 32'(prog_count), 32'd0);
        tick();
        chk("empty_done_once", 32'(done), 32'd0);

        // reset on the second transfer cycle of a five-word run
        for (int i = 1; i <= 5; i++) begin
            load(12'(12'h100 + i));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("r5_w0", 12'h101);
        tick();
        chk_word("r5_w1", 12'h102);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_rst");
        tick();
        chk("rst_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_empty_done", 32'(done), 32'd1);
        tick();

`ifdef ISSUE_REPEAT_EN
        // looping two-word program, then a final pass ending on word1
        load(12'hA01);
        load(12'hB02);
        repeat_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_word("rp_0", 12'hA01);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk_word("rp_n", (i % 2 == 1) ? 12'hB02 : 12'hA01);
            chk("rp_no_done", 32'(done), 32'd0);
        end
        repeat_mode = 1'b0;
        tick();
        chk("rp_end_done", 32'(done), 32'd1);
        chk("rp_end_valid", 32'(out_valid), 32'd0);
        tick();
        chk("rp_done_once", 32'(done), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
